// File: rtl/rob_retire_ctrl_pkg.sv
// rtl/rob_retire_ctrl_pkg.sv - shared types and constants for ROB retirement control
`ifndef SD
`define SD
`endif

package rob_retire_ctrl_pkg;
    localparam int PRF_IDX_DEF = 6;
    localparam int ROB_IDX     = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2,
        HALT    = 2'd3
    } retire_state_t;
endpackage

// File: rtl/rob_retire_ctrl.sv
// rtl/rob_retire_ctrl.sv - 2-wide in-order retirement, mispredict recovery and halt sequencing
module rob_retire_ctrl
    import rob_retire_ctrl_pkg::*;
#(
    parameter int PRF_IDX        = PRF_IDX_DEF,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               h1_valid,
    input  logic               h1_done,
    input  logic               h1_mispred,
    input  logic               h1_halt,
    input  logic [63:0]        h1_target,
    input  logic [PRF_IDX-1:0] h1_pdest,
    input  logic               h2_valid,
    input  logic               h2_done,
    input  logic               h2_mispred,
    input  logic               h2_halt,
    input  logic [63:0]        h2_target,
    input  logic [PRF_IDX-1:0] h2_pdest,
    output logic               retire1,
    output logic               retire2,
    output logic [PRF_IDX-1:0] free_pdest1,
    output logic [PRF_IDX-1:0] free_pdest2,
    output logic               flush,
    output logic [63:0]        redirect_pc,
    output logic               stall_dispatch,
    output logic               halted,
    output logic [CNT_W-1:0]   retired_cnt
);
    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

    retire_state_t state, next_state;
    logic [RC_W-1:0] rec_cnt, next_rec_cnt;
    logic [63:0]     next_redirect;
    logic            young_mispred, young_halt;
    logic [63:0]     young_target;

    assign free_pdest1 = h1_pdest;
    assign free_pdest2 = h2_pdest;

    always_comb begin
        next_state    = state;
        next_rec_cnt  = rec_cnt;
        next_redirect = redirect_pc;
        retire1       = 1'b0;
        retire2       = 1'b0;
        young_mispred = 1'b0;
        young_halt    = 1'b0;
        young_target  = h1_target;
        case (state)
            RUN: begin
                retire1 = h1_valid & h1_done;
                retire2 = retire1 & h2_valid & h2_done & ~h1_mispred & ~h1_halt;
                // The youngest retiring entry decides the next state
                if (retire2) begin
                    young_mispred = h2_mispred;
                    young_halt    = h2_halt;
                    young_target  = h2_target;
                end else if (retire1) begin
                    young_mispred = h1_mispred;
                    young_halt    = h1_halt;
                end
                if (young_mispred) begin
                    next_state    = FLUSH;
                    next_redirect = young_target;
                end else if (young_halt) begin
                    next_state = HALT;
                end
            end
            FLUSH: begin
                next_rec_cnt = RC_W'(RECOVER_CYCLES - 1);
                next_state   = RECOVER;
            end
            RECOVER: begin
                if (rec_cnt == '0) next_state = RUN;
                else next_rec_cnt = rec_cnt - RC_W'(1);
            end
            HALT: next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            rec_cnt        <= '0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            stall_dispatch <= 1'b0;
            halted         <= 1'b0;
            retired_cnt    <= '0;
        end else begin
            state          <= next_state;
            rec_cnt        <= next_rec_cnt;
            redirect_pc    <= next_redirect;
            flush          <= (next_state == FLUSH);
            stall_dispatch <= (next_state == FLUSH) || (next_state == RECOVER);
            halted         <= (next_state == HALT);
            retired_cnt    <= retired_cnt + {{(CNT_W-1){1'b0}}, retire1}
                                          + {{(CNT_W-1){1'b0}}, retire2};
        end
    end
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// tb/tb_rob_retire_ctrl.sv - directed table-driven bench for rob_retire_ctrl
module tb_rob_retire_ctrl;
    localparam int PRF_IDX = 6;
    localparam int RECOVER_CYCLES = 2;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic h1_valid, h1_done, h1_mispred, h1_halt;
    logic h2_valid, h2_done, h2_mispred, h2_halt;
    logic [63:0] h1_target, h2_target;
    logic [PRF_IDX-1:0] h1_pdest, h2_pdest;
    logic retire1, retire2, flush, stall_dispatch, halted;
    logic [PRF_IDX-1:0] free_pdest1, free_pdest2;
    logic [63:0] redirect_pc;
    logic [CNT_W-1:0] retired_cnt;

    int total = 0;
    int passed = 0;
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    rob_retire_ctrl #(.PRF_IDX(PRF_IDX), .RECOVER_CYCLES(RECOVER_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .h1_valid(h1_valid), .h1_done(h1_done), .h1_mispred(h1_mispred), .h1_halt(h1_halt),
        .h1_target(h1_target), .h1_pdest(h1_pdest),
        .h2_valid(h2_valid), .h2_done(h2_done), .h2_mispred(h2_mispred), .h2_halt(h2_halt),
        .h2_target(h2_target), .h2_pdest(h2_pdest),
        .retire1(retire1), .retire2(retire2), .free_pdest1(free_pdest1), .free_pdest2(free_pdest2),
        .flush(flush), .redirect_pc(redirect_pc), .stall_dispatch(stall_dispatch),
        .halted(halted), .retired_cnt(retired_cnt)
    );

    typedef struct {
        logic [3:0] h1;   // valid, done, mispred, halt
        logic [3:0] h2;
        logic       r1;
        logic       r2;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic set_heads(input logic [3:0] a, input logic [3:0] b);
        {h1_valid, h1_done, h1_mispred, h1_halt} = a;
        {h2_valid, h2_done, h2_mispred, h2_halt} = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_heads(4'b0000, 4'b0000);
        h1_target = 64'h0; h2_target = 64'h0;
        h1_pdest = 6'd0; h2_pdest = 6'd0;
        tick(); tick();
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_stall", stall_dispatch, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", retired_cnt, 0);
        reset = 1'b0;
        exp_cnt = '0;

        // Vectors that never change state: only non-retiring entries carry mispred/halt
        vecs[0] = '{4'b1100, 4'b1100, 1'b1, 1'b1};
        vecs[1] = '{4'b1100, 4'b1100, 1'b1, 1'b1};
        vecs[2] = '{4'b1100, 4'b1100, 1'b1, 1'b1};
        vecs[3] = '{4'b1100, 4'b1000, 1'b1, 1'b0};
        vecs[4] = '{4'b1000, 4'b1100, 1'b0, 1'b0};
        vecs[5] = '{4'b0100, 4'b1100, 1'b0, 1'b0};
        vecs[6] = '{4'b1100, 4'b0100, 1'b1, 1'b0};
        vecs[7] = '{4'b0111, 4'b1100, 1'b0, 1'b0};
        vecs[8] = '{4'b1010, 4'b1100, 1'b0, 1'b0};
        vecs[9] = '{4'b1100, 4'b1011, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            set_heads(vecs[i].h1, vecs[i].h2);
            h1_pdest = 6'(2*i + 1);
            h2_pdest = 6'(2*i + 2);
            #1;
            chk($sformatf("v%0d_retire1", i), retire1, vecs[i].r1);
            chk($sformatf("v%0d_retire2", i), retire2, vecs[i].r2);
            chk($sformatf("v%0d_pdest1", i), free_pdest1, 6'(2*i + 1));
            chk($sformatf("v%0d_pdest2", i), free_pdest2, 6'(2*i + 2));
            exp_cnt = exp_cnt + CNT_W'(vecs[i].r1) + CNT_W'(vecs[i].r2);
            tick();
            chk($sformatf("v%0d_cnt", i), retired_cnt, exp_cnt);
            chk($sformatf("v%0d_noflush", i), flush, 0);
            chk($sformatf("v%0d_nostall", i), stall_dispatch, 0);
        end

        // h1 mispredicted (and also halt: mispredict wins), target 0x1000
        set_heads(4'b1111, 4'b1100);
        h1_target = 64'h1000; h2_target = 64'hdead;
        #1;
        chk("mp1_retire1", retire1, 1);
        chk("mp1_retire2", retire2, 0);
        tick();
        exp_cnt = exp_cnt + 1;
        chk("mp1_cnt", retired_cnt, exp_cnt);
        chk("mp1_flush", flush, 1);
        chk("mp1_redirect", redirect_pc, 64'h1000);
        chk("mp1_halted", halted, 0);
        set_heads(4'b1100, 4'b1100);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mp1_stall_c%0d", c), stall_dispatch, 1);
            chk($sformatf("mp1_flush_c%0d", c), flush, (c == 0) ? 1 : 0);
            chk($sformatf("mp1_blocked_c%0d", c), {retire1, retire2}, 2'b00);
            tick();
        end
        chk("mp1_stall_end", stall_dispatch, 0);
        chk("mp1_resume", {retire1, retire2}, 2'b11);
        chk("mp1_cnt_held", retired_cnt, exp_cnt);
        set_heads(4'b0000, 4'b0000);
        tick();

        // h2 mispredicted, target 0x2040
        set_heads(4'b1100, 4'b1110);
        h1_target = 64'hbeef; h2_target = 64'h2040;
        #1;
        chk("mp2_retire", {retire1, retire2}, 2'b11);
        tick();
        exp_cnt = exp_cnt + 2;
        chk("mp2_cnt", retired_cnt, exp_cnt);
        chk("mp2_flush", flush, 1);
        chk("mp2_redirect", redirect_pc, 64'h2040);
        set_heads(4'b0000, 4'b0000);
        tick();
        chk("mp2_flush_drop", flush, 0);
        tick(); tick();
        chk("mp2_stall_end", stall_dispatch, 0);

        // Reset during RECOVER aborts the sequence
        set_heads(4'b1110, 4'b0000);
        h1_target = 64'h3000;
        tick();
        set_heads(4'b1100, 4'b1100);
        tick();
        chk("rr_in_recover", {flush, stall_dispatch}, 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rr_stall", stall_dispatch, 0);
        chk("rr_flush", flush, 0);
        chk("rr_cnt", retired_cnt, 0);
        chk("rr_retire", {retire1, retire2}, 2'b11);
        tick();
        chk("rr_cnt2", retired_cnt, 2);
        chk("rr_no_pulse", {flush, stall_dispatch}, 2'b00);

        // h1 halt with h2 done
        set_heads(4'b1101, 4'b1100);
        #1;
        chk("halt_retire", {retire1, retire2}, 2'b10);
        tick();
        chk("halt_cnt", retired_cnt, 3);
        set_heads(4'b1100, 4'b1100);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("halt_c%0d", c), {halted, retire1, retire2, flush}, 4'b1000);
            tick();
        end
        chk("halt_cnt_held", retired_cnt, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_heads(4'b0000, 4'b0000);
        #1;
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_cnt", retired_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rob_retire_ctrl.md
Name: rob_retire_ctrl

Overview:
In-order retirement controller for the 2-wide reorder buffer. Each cycle it inspects the two oldest ROB entries (head, head+1) and decides how many retire (0, 1 or 2). It also sequences branch-mispredict recovery (flush plus redirect plus dispatch stall) and the halt condition. Its retire outputs drive the ROB pop requests; its flush output drives the ROB tail reset and the map-table recovery.

Parameters:
PRF_IDX, 6, physical register index width
RECOVER_CYCLES, 2, cycles dispatch stays stalled after a flush pulse (at least 1)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
h1_valid  in  1  head entry is allocated
h1_done  in  1  head entry has completed execution
h1_mispred  in  1  head entry is a mispredicted branch
h1_halt  in  1  head entry is a halt instruction
h1_target  in  64  correct PC for head entry if mispredicted
h1_pdest  in  PRF_IDX  head entry destination PRF index
h2_valid, h2_done, h2_mispred, h2_halt, h2_target, h2_pdest  in  same widths  same fields for head+1
retire1  out  1  pop head this cycle (combinational)
retire2  out  1  pop head+1 this cycle (combinational)
free_pdest1  out  PRF_IDX  equals h1_pdest; meaningful only when retire1=1
free_pdest2  out  PRF_IDX  equals h2_pdest; meaningful only when retire2=1
flush  out  1  one-cycle registered pulse: squash all ROB/RS contents
redirect_pc  out  64  registered; fetch target, valid only while flush=1
stall_dispatch  out  1  registered; high during flush and recovery
halted  out  1  registered, sticky until reset
retired_cnt  out  CNT_W  running count of retired instructions

Behaviour:
- FSM states: RUN, FLUSH, RECOVER, HALT. Reset forces RUN; reset mid-FLUSH or mid-RECOVER aborts the sequence with no residual pulse.
- Reset values: flush=0, redirect_pc=0, stall_dispatch=0, halted=0, retired_cnt=0, recovery counter=0.
- retire1 and retire2 are forced to 0 in every state except RUN.
- RUN retire rules:
  - retire1 = h1_valid & h1_done.
  - retire2 = retire1 & h2_valid & h2_done & !h1_mispred & !h1_halt.
  - Retirement is strictly in order: h2 never retires without h1.
  - An h2 that is mispredicted or a halt does retire in slot 2.
- RUN transitions, decided by the youngest retiring entry:
  - If that entry is mispredicted, go to FLUSH next cycle; latch its target into redirect_pc.
  - Otherwise, if that entry is a halt, go to HALT next cycle.
  - If h1 is mispredicted and h1 is also a halt, the mispredict takes priority.
- FLUSH (exactly 1 cycle):
  - flush=1, stall_dispatch=1, redirect_pc valid.
  - Load recovery counter with RECOVER_CYCLES-1, then go to RECOVER.
  - Head inputs are ignored in this state.
- RECOVER:
  - flush=0, stall_dispatch=1.
  - Counter decrements each cycle; when it is 0, go to RUN and drop stall_dispatch on entry to RUN.
  - Total stall = 1 + RECOVER_CYCLES cycles.
- HALT: halted=1 from the cycle after the halt retires; no retires, no flush. Left only via reset.
- retired_cnt: increments by retire1+retire2 in the same clock edge as the retire. Wraps modulo 2^CNT_W.
- Entries with h*_valid=0 never retire, regardless of done/mispred/halt (treat those inputs as X).

Decomposition:
- Shared package: FSM state enum (2-bit), PRF_IDX/ROB_IDX defines, and the `SD delay macro already used in the codebase.
- No sub-module. The recovery down-counter stays inline.

Test Plan:
- Normal dual retire: both heads valid and done for 3 cycles -> retire1=retire2=1 each cycle; retired_cnt 0->2->4->6; free_pdest tracks h1/h2_pdest.
- Partial retire: h1 done, h2 valid but not done -> retire1=1, retire2=0. Then h1 not done, h2 done -> both 0 (in-order).
- h1 mispredicted, target 0x1000, RECOVER_CYCLES=2 -> retire1=1, retire2=0. Next cycle flush=1 with redirect_pc=0x1000. stall_dispatch high for 3 cycles; retires blocked; back to RUN in cycle 4.
- h2 mispredicted, target 0x2040, h1 normal -> both retire, retired_cnt+2; flush with redirect_pc=0x2040 the following cycle.
- h1 halt with h2 done -> only retire1. halted=1 next cycle and stays 1 for 10 cycles with retire outputs 0; reset clears halted and retired_cnt.
- Reset asserted during RECOVER -> next cycle stall_dispatch=0, flush=0, FSM in RUN, retires resume as soon as heads are done.
